// File: rtl/serie_pkg.sv
// Shared types and constants for the serie_parallel_tx slice.
//   serie_state_t  : transmitter FSM states (IDLE, SHIFT, PARITY, GAP_ST)
//   DIR_MSB_FIRST  : LeRi value selecting left shift, MSB out first
//   DIR_LSB_FIRST  : LeRi value selecting right shift, LSB out first
//   cnt_width()    : counter width able to hold 0..n, never below 1 bit
package serie_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    GAP_ST = 2'd3
  } serie_state_t;

  localparam logic DIR_MSB_FIRST = 1'b1;
  localparam logic DIR_LSB_FIRST = 1'b0;

  // $clog2(n+1) bits hold 0..n; a zero-width counter (n == 0) is widened to 1.
  function automatic int cnt_width(input int n);
    return ($clog2(n + 1) < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serie_parallel_tx_if.sv
// Bus of the parallel-in / serial-out transmitter.
//   Ena, LeRi             : bit strobe and shift direction
//   Load_Data/Valid/Ready : word load handshake
//   Data_Out, Frame_Out   : serial bit and its frame qualifier
//   Done                  : one-cycle end-of-frame pulse
//   Dbg_State             : current FSM state, for observation only
// Handshake: a word transfers on a Clk rising edge where Load_Valid and
// Load_Ready are both high. Load_Valid while Load_Ready is low is ignored
// and nothing is queued; the producer keeps Load_Data stable while it waits.
// Modports: master = word/strobe producer, slave = transmitter.
interface serie_parallel_tx_if
  import serie_pkg::*;
#(
  parameter int WIDTH = 4
) ();

  logic             Ena;
  logic             LeRi;
  logic [WIDTH-1:0] Load_Data;
  logic             Load_Valid;
  logic             Load_Ready;
  logic             Data_Out;
  logic             Frame_Out;
  logic             Done;
  serie_state_t     Dbg_State;

  modport master (
    output Ena, LeRi, Load_Data, Load_Valid,
    input  Load_Ready, Data_Out, Frame_Out, Done, Dbg_State
  );

  modport slave (
    input  Ena, LeRi, Load_Data, Load_Valid,
    output Load_Ready, Data_Out, Frame_Out, Done, Dbg_State
  );

endinterface

// File: rtl/serie_bit_counter.sv
// Loadable up-counter with enable and terminal-count flag.
//   Clk, Rst  : clock, asynchronous active-low reset (count -> 0)
//   load      : synchronous load of load_val (has priority over en)
//   load_val  : value loaded
//   en        : count up by one
//   count     : current value
//   tc        : count equals TC_VAL
module serie_bit_counter #(
  parameter int W      = 2,
  parameter int TC_VAL = 0
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign tc = (count == W'(TC_VAL));

endmodule

// File: rtl/serie_parallel_tx.sv
// Parallel-in, serial-out transmitter. Takes a WIDTH-bit word on the load
// handshake and shifts it out one bit per Ena strobe, MSB-first (LeRi=1) or
// LSB-first (LeRi=0); the direction is latched with the word. GAP idle Ena
// strobes follow every frame.
//   Clk, Rst : clock (rising edge), asynchronous active-low reset
//   bus      : serie_parallel_tx_if slave (Ena, LeRi, load handshake,
//              Data_Out, Frame_Out, Done, Dbg_State)
// Build option: define SERIE_TX_PARITY_EN to append one even-parity bit to
// every frame (frame = WIDTH+1 strobes, Done at the end of the parity bit).
// All outputs come from registers; none depends combinationally on inputs.
module serie_parallel_tx
  import serie_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input logic                Clk,
  input logic                Rst,
  serie_parallel_tx_if.slave bus
);

  localparam int BW = cnt_width(WIDTH);
  localparam int GW = cnt_width(GAP);

  serie_state_t     state_q, state_d;
  logic [WIDTH-1:0] sreg_q;
  logic             dir_q;
  logic             done_q, done_d;
  logic             accept, last_edge;
  logic             bit_clr, bit_inc, bit_tc;
  logic             gap_clr, gap_inc, gap_tc;
  logic [BW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             tail_bit;

  assign accept = (state_q == IDLE) && bus.Load_Valid;

  serie_bit_counter #(.W(BW), .TC_VAL(WIDTH - 1)) u_bit_cnt (
    .Clk(Clk), .Rst(Rst), .load(bit_clr), .load_val('0),
    .en(bit_inc), .count(bit_cnt), .tc(bit_tc)
  );

  // With GAP == 0 the gap state is never entered; TC_VAL only has to be legal.
  serie_bit_counter #(.W(GW), .TC_VAL((GAP > 0) ? GAP - 1 : 0)) u_gap_cnt (
    .Clk(Clk), .Rst(Rst), .load(gap_clr), .load_val('0),
    .en(gap_inc), .count(gap_cnt), .tc(gap_tc)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_clr   = 1'b0;
    bit_inc   = 1'b0;
    gap_clr   = 1'b0;
    gap_inc   = 1'b0;
    last_edge = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.Load_Valid) begin
          bit_clr = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.Ena) begin
          bit_inc = 1'b1;
          if (bit_tc) begin
`ifdef SERIE_TX_PARITY_EN
            state_d = PARITY;
`else
            last_edge = 1'b1;
`endif
          end
        end
      end
      PARITY: begin
`ifdef SERIE_TX_PARITY_EN
        if (bus.Ena) begin
          last_edge = 1'b1;
        end
`else
        state_d = IDLE;
`endif
      end
      GAP_ST: begin
        if (bus.Ena) begin
          gap_inc = 1'b1;
          if (gap_tc) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Common end-of-frame step, from the last data bit or the parity bit.
    if (last_edge) begin
      done_d = 1'b1;
      if (GAP > 0) begin
        gap_clr = 1'b1;
        state_d = GAP_ST;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sreg_q <= '0;
      dir_q  <= DIR_LSB_FIRST;
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
      if (accept) begin
        sreg_q <= bus.Load_Data;
        dir_q  <= bus.LeRi;
      end else if ((state_q == SHIFT) && bus.Ena) begin
        sreg_q <= (dir_q == DIR_MSB_FIRST) ? (sreg_q << 1) : (sreg_q >> 1);
      end
    end
  end

`ifdef SERIE_TX_PARITY_EN
  // Parity is taken from the word at capture, since the shifter empties out.
  logic par_q;
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      par_q <= 1'b0;
    end else if (accept) begin
      par_q <= ^bus.Load_Data;
    end
  end
  assign tail_bit = (state_q == PARITY) ? par_q : 1'b0;
`else
  assign tail_bit = 1'b0;
`endif

  assign bus.Load_Ready = (state_q == IDLE);
  assign bus.Frame_Out  = (state_q == SHIFT) || (state_q == PARITY);
  assign bus.Data_Out   = (state_q == SHIFT)
                          ? ((dir_q == DIR_MSB_FIRST) ? sreg_q[WIDTH-1] : sreg_q[0])
                          : tail_bit;
  assign bus.Done       = done_q;
  assign bus.Dbg_State  = state_q;

endmodule

// File: tb/tb_serie_parallel_tx.sv
// Bench for serie_parallel_tx: dut_a (GAP=1) carries the directed and random
// frames, dut_b (GAP=0) the back-to-back frames with Load_Valid held high.
// Expected waveforms come from frame arithmetic: bit i of a frame is visible
// during the p cycles before strobe i+1, Done follows the last strobe, and
// Load_Ready returns after the GAP strobe.
module tb_serie_parallel_tx;

  localparam int W = 4;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;
  logic [0:0] exp_q[$];

  serie_parallel_tx_if #(.WIDTH(W)) ifa ();
  serie_parallel_tx_if #(.WIDTH(W)) ifb ();

  serie_parallel_tx #(.WIDTH(W), .GAP(1)) dut_a (.Clk(Clk), .Rst(Rst), .bus(ifa));
  serie_parallel_tx #(.WIDTH(W), .GAP(0)) dut_b (.Clk(Clk), .Rst(Rst), .bus(ifb));

  // ---------------- clock ----------------
  always #5 Clk = ~Clk;

  // ---------------- reference model ----------------
  function automatic int model_len();
`ifdef SERIE_TX_PARITY_EN
    return W + 1;
`else
    return W;
`endif
  endfunction

  // i-th transmitted bit of a frame; index W is the parity bit.
  function automatic logic model_bit(input logic [W-1:0] w, input logic dir, input int i);
    if (i >= W) return ^w;
    return dir ? w[W-1-i] : w[i];
  endfunction

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // ---------------- driver: one frame on dut_a ----------------
  // p = Ena period in cycles; tog = wiggle LeRi during the frame.
  // Load_Valid is randomised while busy and must be ignored.
  task automatic run_frame(input logic [W-1:0] word, input logic dir, input int p,
                           input bit tog, input string nm);
    int   len;
    int   last;
    logic fr;
    logic ed;
    len  = model_len();
    last = (len + 1) * p + 1;
    @(posedge Clk); #1;
    ifa.Load_Valid = 1'b1;
    ifa.Load_Data  = word;
    ifa.LeRi       = dir;
    ifa.Ena        = 1'($urandom_range(0, 1));
    @(negedge Clk);
    chk({nm, "_rdy0"}, 32'(ifa.Load_Ready), 32'd1);
    for (int c = 1; c <= last; c++) begin
      @(posedge Clk); #1;
      ifa.Load_Valid = (c == last) ? 1'b0 : 1'($urandom_range(0, 1));
      ifa.Load_Data  = W'($urandom);
      ifa.Ena        = ((c % p) == 0);
      if (tog) ifa.LeRi = dir ^ 1'(c % 2);
      @(negedge Clk);
      fr = (c <= len * p);
      ed = fr ? model_bit(word, dir, (c - 1) / p) : 1'b0;
      chk($sformatf("%s_dat%0d", nm, c), 32'(ifa.Data_Out), 32'(ed));
      chk($sformatf("%s_frm%0d", nm, c), 32'(ifa.Frame_Out), 32'(fr));
      chk($sformatf("%s_don%0d", nm, c), 32'(ifa.Done), 32'(c == len * p + 1));
      chk($sformatf("%s_rdy%0d", nm, c), 32'(ifa.Load_Ready), 32'(c == last));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int len;
    int pos;
    ifa.Ena = 1'b0; ifa.LeRi = 1'b0; ifa.Load_Data = '0; ifa.Load_Valid = 1'b0;
    ifb.Ena = 1'b0; ifb.LeRi = 1'b0; ifb.Load_Data = '0; ifb.Load_Valid = 1'b0;

    // reset state
    repeat (2) @(negedge Clk);
    chk("rst_rdy", 32'(ifa.Load_Ready), 32'd1);
    chk("rst_frm", 32'(ifa.Frame_Out), 32'd0);
    chk("rst_dat", 32'(ifa.Data_Out), 32'd0);
    chk("rst_don", 32'(ifa.Done), 32'd0);
    Rst = 1'b1;

    // directed frames: MSB-first, LSB-first with LeRi wiggle, slow strobe
    run_frame(4'b1011, 1'b1, 1, 1'b0, "t1");
    run_frame(4'b1011, 1'b0, 1, 1'b1, "t2");
    run_frame(4'b0110, 1'b1, 3, 1'b0, "t3");

    // reset in the middle of a frame, after two bits
    @(posedge Clk); #1;
    ifa.Load_Valid = 1'b1; ifa.Load_Data = 4'b1111; ifa.LeRi = 1'b1; ifa.Ena = 1'b1;
    @(negedge Clk);
    chk("t4_rdy0", 32'(ifa.Load_Ready), 32'd1);
    for (int c = 1; c <= 2; c++) begin
      @(posedge Clk); #1;
      ifa.Load_Valid = 1'b0;
      @(negedge Clk);
      chk($sformatf("t4_dat%0d", c), 32'(ifa.Data_Out), 32'd1);
    end
    @(posedge Clk); #2;
    Rst = 1'b0;
    #1;
    chk("t4_rst_dat", 32'(ifa.Data_Out), 32'd0);
    chk("t4_rst_frm", 32'(ifa.Frame_Out), 32'd0);
    chk("t4_rst_rdy", 32'(ifa.Load_Ready), 32'd1);
    chk("t4_rst_don", 32'(ifa.Done), 32'd0);
    @(negedge Clk);
    Rst = 1'b1;
    run_frame(4'b1001, 1'b1, 1, 1'b0, "t4b");

    // parity-relevant words (plain frames in the default build)
    run_frame(4'b0111, 1'b1, 1, 1'b0, "t6a");
    run_frame(4'b0011, 1'b0, 2, 1'b0, "t6b");

    // random frames
    for (int k = 0; k < 12; k++) begin
      run_frame(W'($urandom), 1'($urandom_range(0, 1)), $urandom_range(1, 3),
                1'($urandom_range(0, 1)), $sformatf("r%0d", k));
    end

    // back-to-back frames on dut_b, Load_Valid held high
    len = model_len();
    exp_q.delete();
    for (int i = 0; i < len; i++) exp_q.push_back(model_bit(4'hA, 1'b1, i));
    for (int i = 0; i < len; i++) exp_q.push_back(model_bit(4'h5, 1'b1, i));
    for (int c = 0; c <= 2 * (len + 1); c++) begin
      @(posedge Clk); #1;
      ifb.Load_Valid = (c < 2 * (len + 1));
      ifb.Load_Data  = (c == 0) ? 4'hA : 4'h5;
      ifb.Ena        = 1'b1;
      ifb.LeRi       = 1'b1;
      @(negedge Clk);
      pos = c % (len + 1);
      if (pos == 0) begin
        chk($sformatf("t5_rdy%0d", c), 32'(ifb.Load_Ready), 32'd1);
        chk($sformatf("t5_frm%0d", c), 32'(ifb.Frame_Out), 32'd0);
        chk($sformatf("t5_don%0d", c), 32'(ifb.Done), 32'(c > 0));
      end else begin
        chk($sformatf("t5_rdy%0d", c), 32'(ifb.Load_Ready), 32'd0);
        chk($sformatf("t5_frm%0d", c), 32'(ifb.Frame_Out), 32'd1);
        chk($sformatf("t5_don%0d", c), 32'(ifb.Done), 32'd0);
        chk($sformatf("t5_dat%0d", c), 32'(ifb.Data_Out), 32'(exp_q.pop_front()));
      end
    end
    ifb.Load_Valid = 1'b0;

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
